// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit holding the HI/LO registers.
//
// Takes the forwarded ALU operands on a one-cycle start pulse and runs
// MULT/MULTU (shift-add, LSB first) or DIV/DIVU (restoring, MSB first) for
// CYCLES iterations, then applies the result signs and writes HI/LO.
// MTHI/MTLO write HI/LO directly from opa in a single cycle.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, op         one-cycle request and opcode
//                     (000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                      100 MTHI, 101 MTLO, 110/111 no-op)
//   opa, opb          operands, two's complement for signed ops
//   flush             squashes an in-flight operation or a same-cycle start
//   busy              high while an operation iterates (pipeline stall)
//   done              one-cycle pulse when HI/LO take a new value
//   div_by_zero       pulses with done for a divide with opb == 0
//   hi, lo            architectural HI/LO registers
module mdu_hilo #(
    parameter int WIDTH  = 32,
    parameter int CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0]        CNT_LAST = CW'(CYCLES - 1);
    localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0]     ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0]   ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } state_t;

    // Magnitude of a value; unsigned operands pass through untouched.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                             input logic is_signed);
        if (is_signed && v[WIDTH-1]) begin
            return ~v + ONE_W;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + ONE_2W;
    endfunction

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   low half holds dividend bits shifting out / quotient shifting in.
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH:0]     rem_r;      // divide partial remainder
    logic [WIDTH-1:0]   mcand_r;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   raw_a_r;    // raw dividend, returned in HI on divide by zero
    logic               is_div_r;
    logic               dbz_r;
    logic               neg_lo_r;   // product / quotient sign
    logic               neg_hi_r;   // remainder sign (dividend sign)

    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH+1:0]   div_shift_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic               q_bit_s;
    logic [WIDTH:0]     div_rem_next_s;
    logic [2*WIDTH-1:0] div_acc_next_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;

    logic               op_signed_s;
    logic               sa_s;
    logic               sb_s;

    // Request decode: sign of each operand for the signed opcodes.
    always_comb begin
        op_signed_s = ~op[0];
        sa_s        = op_signed_s & opa[WIDTH-1];
        sb_s        = op_signed_s & opb[WIDTH-1];
    end

    // One iteration of shift-add multiply and restoring divide, plus final sign fix-up.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
                   + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};

        // The extra top bit makes the subtract borrow visible as a sign bit.
        div_shift_s    = {rem_r, acc_r[WIDTH-1]};
        div_diff_s     = div_shift_s - {2'b00, mcand_r};
        q_bit_s        = ~div_diff_s[WIDTH+1];
        div_rem_next_s = q_bit_s ? div_diff_s[WIDTH:0] : div_shift_s[WIDTH:0];
        div_acc_next_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], q_bit_s};

        prod_s   = neg_lo_r ? neg_2w(acc_r) : acc_r;
        res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        res_lo_s = prod_s[WIDTH-1:0];
        if (is_div_r) begin
            if (dbz_r) begin
                res_hi_s = raw_a_r;
                res_lo_s = {WIDTH{1'b1}};
            end else begin
                res_lo_s = neg_lo_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
                res_hi_s = neg_hi_r ? neg_w(rem_r[WIDTH-1:0]) : rem_r[WIDTH-1:0];
            end
        end else begin
            res_hi_s = prod_s[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            rem_r       <= {(WIDTH+1){1'b0}};
            mcand_r     <= {WIDTH{1'b0}};
            raw_a_r     <= {WIDTH{1'b0}};
            is_div_r    <= 1'b0;
            dbz_r       <= 1'b0;
            neg_lo_r    <= 1'b0;
            neg_hi_r    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= {WIDTH{1'b0}};
            lo          <= {WIDTH{1'b0}};
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && !flush) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                acc_r    <= {{WIDTH{1'b0}}, mag(opa, op_signed_s)};
                                mcand_r  <= mag(opb, op_signed_s);
                                rem_r    <= {(WIDTH+1){1'b0}};
                                raw_a_r  <= opa;
                                is_div_r <= op[1];
                                dbz_r    <= op[1] & (opb == {WIDTH{1'b0}});
                                neg_lo_r <= sa_s ^ sb_s;
                                neg_hi_r <= sa_s;
                                cnt_r    <= {CW{1'b0}};
                                busy     <= 1'b1;
                                state_r  <= ST_CALC;
                            end
                            OP_MTHI: begin
                                hi   <= opa;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= opa;
                                done <= 1'b1;
                            end
                            default: begin
                                // no-op codes leave everything untouched
                            end
                        endcase
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_IDLE;
                    end else begin
                        if (is_div_r) begin
                            acc_r <= div_acc_next_s;
                            rem_r <= div_rem_next_s;
                        end else begin
                            acc_r <= mul_next_s;
                        end
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            state_r <= ST_SIGN;
                        end else begin
                            state_r <= ST_CALC;
                        end
                    end
                end
                ST_SIGN: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_IDLE;
                    end else begin
                        hi          <= res_hi_s;
                        lo          <= res_lo_s;
                        done        <= 1'b1;
                        div_by_zero <= dbz_r;
                        busy        <= 1'b0;
                        cnt_r       <= {CW{1'b0}};
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: an arithmetic reference model checked
// against the DUT every cycle, plus hand-computed expectations per vector.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b111;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    mdu_hilo #(.WIDTH(32), .CYCLES(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
        .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the instruction definitions.
    function automatic void calc(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l, output logic z);
        longint p, q, r, sa, sb;
        logic [63:0] u;
        z = 1'b0;
        h = 32'd0;
        l = 32'd0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            3'b000: begin p = sa * sb; u = p; h = u[63:32]; l = u[31:0]; end
            3'b001: begin u = {32'd0, a} * {32'd0, b}; h = u[63:32]; l = u[31:0]; end
            3'b010, 3'b011: begin
                if (b == 32'd0) begin
                    z = 1'b1; l = 32'hFFFF_FFFF; h = a;
                end else begin
                    if (o == 3'b011) begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    u = q; l = u[31:0];
                    u = r; h = u[31:0];
                end
            end
            default: ;
        endcase
    endfunction

    // Model state: pending result delivered after 33 edges.
    logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
    logic        p_dbz = 1'b0;
    int          remaining = 0;

    always @(posedge clk or posedge rst) begin
        logic [31:0] th, tl;
        logic tz;
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_hi <= 32'd0; m_lo <= 32'd0; remaining <= 0;
        end else begin
            m_done <= 1'b0;
            m_dbz  <= 1'b0;
            if (remaining > 0) begin
                if (flush) begin
                    remaining <= 0;
                    m_busy <= 1'b0;
                end else begin
                    remaining <= remaining - 1;
                    if (remaining == 1) begin
                        m_hi <= p_hi; m_lo <= p_lo;
                        m_done <= 1'b1; m_dbz <= p_dbz; m_busy <= 1'b0;
                    end
                end
            end else if (start && !flush) begin
                if (op <= 3'd3) begin
                    calc(op, opa, opb, th, tl, tz);
                    p_hi <= th; p_lo <= tl; p_dbz <= tz;
                    remaining <= 33;
                    m_busy <= 1'b1;
                end else if (op == 3'd4) begin
                    m_hi <= opa; m_done <= 1'b1;
                end else if (op == 3'd5) begin
                    m_lo <= opa; m_done <= 1'b1;
                end
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_busy});
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; opa = a; opb = b;
        cyc();
        start = 1'b0; op = 3'b111;
    endtask

    task automatic wait_done(input string name, output int nbusy, output logic z);
        logic ok;
        nbusy = 0; z = 1'b0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                z = div_by_zero; ok = 1'b1;
                break;
            end
        end
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: done not seen within 40 cycles", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        logic z;
        rst = 1'b1;
        @(negedge clk);
        chk("reset_hi", hi, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        issue(3'b000, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_done("mult_neg", nb, z);
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFF1);
        chk("mult_busy_cycles", nb, 32'd33);

        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu_max", nb, z);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("mult_m1", nb, z);
        chk("mult_m1_hi", hi, 32'h0000_0000);
        chk("mult_m1_lo", lo, 32'h0000_0001);

        issue(3'b010, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", nb, z);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", nb, z);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'h0000_0000);
        chk("div_ovf_dbz", {31'd0, z}, 32'd0);
        issue(3'b011, 32'd100, 32'd7);
        wait_done("divu", nb, z);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        issue(3'b011, 32'h1234_5678, 32'd0);
        wait_done("divu_zero", nb, z);
        chk("dbz_lo", lo, 32'hFFFF_FFFF);
        chk("dbz_hi", hi, 32'h1234_5678);
        chk("dbz_flag", {31'd0, z}, 32'd1);
        chk("dbz_busy_cycles", nb, 32'd33);

        // MTHI then MTLO back to back
        start = 1'b1; op = 3'b100; opa = 32'hDEAD_BEEF;
        cyc();
        op = 3'b101; opa = 32'h0000_CAFE;
        @(negedge clk);
        chk("mthi_done", {31'd0, done}, 32'd1);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        cyc();
        start = 1'b0; op = 3'b111;
        @(negedge clk);
        chk("mtlo_done", {31'd0, done}, 32'd1);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mt_hi", hi, 32'hDEAD_BEEF);
        chk("mt_lo", lo, 32'h0000_CAFE);

        // Flush mid-multiply keeps preloaded HI/LO
        issue(3'b100, 32'd1, 32'd0);
        issue(3'b101, 32'd2, 32'd0);
        issue(3'b000, 32'd3, 32'd4);
        repeat (8) cyc();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_hi", hi, 32'd1);
        chk("flush_lo", lo, 32'd2);
        repeat (40) cyc();
        chk("flush_no_done_hi", hi, 32'd1);

        // Reset mid-multiply clears everything at once
        issue(3'b000, 32'd3, 32'd4);
        repeat (18) cyc();
        rst = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        cyc();
        rst = 1'b0;
        cyc();

        // Start during a busy divide is ignored
        issue(3'b011, 32'd1000, 32'd3);
        repeat (4) cyc();
        start = 1'b1; op = 3'b100; opa = 32'h0000_0055;
        cyc();
        start = 1'b0; op = 3'b111;
        wait_done("divu_ignore", nb, z);
        chk("ignore_lo", lo, 32'h0000_014D);
        chk("ignore_hi", hi, 32'h0000_0001);

        // Flush in IDLE drops MTHI; no-op code gives no done
        flush = 1'b1;
        issue(3'b100, 32'h0000_0077, 32'd0);
        flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_done", {31'd0, done}, 32'd0);
        chk("idle_flush_hi", hi, 32'h0000_0001);
        issue(3'b110, 32'h0000_0099, 32'd0);
        @(negedge clk);
        chk("noop_done", {31'd0, done}, 32'd0);
        chk("noop_lo", lo, 32'h0000_014D);
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
